// File: rtl/hc595_rx_if.sv
// ----------------------------------------------------------------------------
// hc595_rx_if
// Bundle for the 74HC595 receive-side checker.
//   Link lines (driven by the transmitter side):
//     ds        serial data
//     shcp      shift clock (sampled as data)
//     stcp      storage/latch clock (sampled as data)
//     oe        output enable, active-low
//   Receiver results:
//     q         latched parallel word, zero while outputs disabled
//     q_en      high when outputs are enabled
//     frame_vld one-cycle pulse when the storage register loads
//     frame_err one-cycle pulse with frame_vld when the bit count was wrong
//     bit_cnt   shifts seen since the last latch, saturating
// The master modport is the transmitter/environment, slave is the receiver.
// ----------------------------------------------------------------------------
interface hc595_rx_if #(
    parameter int WIDTH = 14,
    parameter int CNT_W = 5
);
    logic             ds;
    logic             shcp;
    logic             stcp;
    logic             oe;
    logic [WIDTH-1:0] q;
    logic             q_en;
    logic             frame_vld;
    logic             frame_err;
    logic [CNT_W-1:0] bit_cnt;

    modport master (
        output ds, shcp, stcp, oe,
        input  q, q_en, frame_vld, frame_err, bit_cnt
    );

    modport slave (
        input  ds, shcp, stcp, oe,
        output q, q_en, frame_vld, frame_err, bit_cnt
    );
endinterface

// File: rtl/hc595_rx.sv
// ----------------------------------------------------------------------------
// hc595_rx
// Receive-side model of a 74HC595 driven over ds/shcp/stcp/oe. All four link
// lines are oversampled in the sys_clk domain; rising edges of shcp and stcp
// are detected from synchronized samples and used to rebuild the 595 shift
// and storage registers.
// Ports:
//   sys_clk    system clock, rising edge
//   sys_rst_n  asynchronous active-low reset
//   link       hc595_rx_if.slave (link inputs, parallel word and strobes)
// Parameters:
//   WIDTH  bits per frame (2..31)
//   CNT_W  bit counter width, 2^CNT_W - 1 >= WIDTH
// ----------------------------------------------------------------------------
module hc595_rx #(
    parameter int WIDTH = 14,
    parameter int CNT_W = 5
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    hc595_rx_if.slave   link
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(WIDTH);

    // Synchronizers. shcp/stcp carry a third stage for edge detection.
    logic ds_s1_reg,   ds_s2_reg;
    logic shcp_s1_reg, shcp_s2_reg, shcp_s3_reg;
    logic stcp_s1_reg, stcp_s2_reg, stcp_s3_reg;
    logic oe_s1_reg,   oe_s2_reg;

    // Rebuilt 595 state
    logic [WIDTH-1:0] sr_reg;
    logic [WIDTH-1:0] store_reg;
    logic [CNT_W-1:0] bit_cnt_reg;
    logic [CNT_W-1:0] bit_cnt_next;
    logic             frame_vld_reg;
    logic             frame_err_reg;

    logic shift_evt;
    logic latch_evt;

    assign shift_evt = shcp_s2_reg & ~shcp_s3_reg;
    assign latch_evt = stcp_s2_reg & ~stcp_s3_reg;

    // A latch clears the count; if a shift lands in the same cycle, that
    // shift is the first bit of the next frame.
    always_comb begin
        bit_cnt_next = bit_cnt_reg;
        if (latch_evt) begin
            bit_cnt_next = shift_evt ? CNT_W'(1) : '0;
        end else if (shift_evt && (bit_cnt_reg != CNT_MAX)) begin
            bit_cnt_next = bit_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ds_s1_reg     <= 1'b0;
            ds_s2_reg     <= 1'b0;
            shcp_s1_reg   <= 1'b0;
            shcp_s2_reg   <= 1'b0;
            shcp_s3_reg   <= 1'b0;
            stcp_s1_reg   <= 1'b0;
            stcp_s2_reg   <= 1'b0;
            stcp_s3_reg   <= 1'b0;
            oe_s1_reg     <= 1'b1;
            oe_s2_reg     <= 1'b1;
            sr_reg        <= '0;
            store_reg     <= '0;
            bit_cnt_reg   <= '0;
            frame_vld_reg <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            ds_s1_reg   <= link.ds;
            ds_s2_reg   <= ds_s1_reg;
            shcp_s1_reg <= link.shcp;
            shcp_s2_reg <= shcp_s1_reg;
            shcp_s3_reg <= shcp_s2_reg;
            stcp_s1_reg <= link.stcp;
            stcp_s2_reg <= stcp_s1_reg;
            stcp_s3_reg <= stcp_s2_reg;
            oe_s1_reg   <= link.oe;
            oe_s2_reg   <= oe_s1_reg;

            // Storage takes the pre-shift sr, matching the 595 where the
            // storage stage is one step behind the shift stage.
            if (latch_evt) begin
                store_reg <= sr_reg;
            end
            if (shift_evt) begin
                sr_reg <= {sr_reg[WIDTH-2:0], ds_s2_reg};
            end

            bit_cnt_reg   <= bit_cnt_next;
            frame_vld_reg <= latch_evt;
            frame_err_reg <= latch_evt && (bit_cnt_reg != CNT_FRAME);
        end
    end

    // Output gating: combinational from registered store and synchronized oe.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_q_gate
            assign link.q[gi] = store_reg[gi] & ~oe_s2_reg;
        end
    endgenerate

    assign link.q_en      = ~oe_s2_reg;
    assign link.frame_vld = frame_vld_reg;
    assign link.frame_err = frame_err_reg;
    assign link.bit_cnt   = bit_cnt_reg;

endmodule

// File: tb/tb_hc595_rx.sv
// ----------------------------------------------------------------------------
// tb_hc595_rx
// Self-checking bench for hc595_rx: a reset phase, a table of whole frames,
// hand-written corner sequences and randomized frames, all checked against a
// bit-history model of the 595.
// ----------------------------------------------------------------------------
module tb_hc595_rx;

    localparam int W     = 14;
    localparam int CW    = 5;
    localparam int SATV  = 31;

    logic sys_clk;
    logic sys_rst_n;

    hc595_rx_if #(.WIDTH(W), .CNT_W(CW)) link ();

    hc595_rx #(.WIDTH(W), .CNT_W(CW)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .link      (link)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: every bit shifted since reset, plus the history index of the
    // most recent latch. sr is the newest W bits; the count is the number of
    // bits since that latch.
    bit           hist[$];
    int           latch_idx;
    logic [W-1:0] m_store;
    bit           m_oe;

    function automatic logic [W-1:0] model_sr();
        logic [W-1:0] r = '0;
        int n = hist.size();
        for (int i = 0; i < W && i < n; i++) r[i] = hist[n-1-i];
        return r;
    endfunction

    function automatic int model_cnt();
        int c = hist.size() - latch_idx;
        return (c > SATV) ? SATV : c;
    endfunction

    function automatic logic [W-1:0] model_q();
        return m_oe ? '0 : m_store;
    endfunction

    task automatic model_reset();
        hist.delete();
        latch_idx = 0;
        m_store   = '0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One link event: optional shcp rise, optional stcp rise, both in the
    // same cycle when both are set. ds is set one cycle before the rise.
    task automatic pulse(input bit sh, input bit la, input bit d,
                         output bit o_err, output logic [W-1:0] o_q);
        int nv = 0, ne = 0, lat = 0;
        bit exp_err;
        o_err = 1'b0;
        o_q   = '0;
        link.ds = d;
        @(negedge sys_clk);
        link.shcp = sh;
        link.stcp = la;
        for (int i = 1; i <= 6; i++) begin
            if (i == 5) begin
                link.shcp = 1'b0;
                link.stcp = 1'b0;
            end
            @(negedge sys_clk);
            if (link.frame_vld) begin
                nv++;
                lat   = i;
                o_err = link.frame_err;
                o_q   = link.q;
            end
            if (link.frame_err) ne++;
        end
        // model update
        exp_err = 1'b0;
        if (la) begin
            exp_err = (model_cnt() != W);
            m_store = model_sr();
        end
        if (sh) hist.push_back(d);
        if (la) latch_idx = hist.size() - (sh ? 1 : 0);

        check("vld_count", nv, la ? 1 : 0);
        check("err_count", ne, (la && exp_err) ? 1 : 0);
        if (la) begin
            check("vld_latency", lat, 3);
            check("err_at_vld", o_err, exp_err);
            check("q_at_vld", o_q, model_q());
        end
        check("bit_cnt", link.bit_cnt, model_cnt());
        check("q", link.q, model_q());
        check("q_en", link.q_en, !m_oe);
    endtask

    task automatic set_oe(input bit v);
        @(negedge sys_clk);
        link.oe = v;
        m_oe    = v;
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic send_bits(input logic [31:0] data, input int nbits);
        bit e;
        logic [W-1:0] qv;
        for (int i = nbits - 1; i >= 0; i--) pulse(1'b1, 1'b0, data[i], e, qv);
    endtask

    typedef struct {
        int           nbits;
        logic [31:0]  data;
        bit           oe;
        int           exp_cnt;
        logic [W-1:0] exp_q;
        bit           exp_err;
    } vec_t;

    vec_t vecs[5];

    initial begin
        bit           e;
        logic [W-1:0] qv;

        vecs[0] = '{14, 32'h2C35,  1'b0, 14, 14'h2C35, 1'b0};
        vecs[1] = '{13, 32'h0AAA,  1'b0, 13, 14'h2AAA, 1'b1};
        vecs[2] = '{20, 32'hFFFFF, 1'b0, 20, 14'h3FFF, 1'b1};
        vecs[3] = '{14, 32'h1234,  1'b1, 14, 14'h0000, 1'b0};
        vecs[4] = '{14, 32'h3A5C,  1'b0, 14, 14'h3A5C, 1'b0};

        // ---------------- reset with the link toggling
        sys_rst_n = 1'b0;
        link.ds = 1'b0; link.shcp = 1'b0; link.stcp = 1'b0; link.oe = 1'b1;
        m_oe = 1'b1;
        model_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            link.ds   = 1'($urandom);
            link.shcp = 1'($urandom);
            link.stcp = 1'($urandom);
            link.oe   = 1'($urandom);
            check("rst_q", link.q, 0);
            check("rst_q_en", link.q_en, 0);
            check("rst_bit_cnt", link.bit_cnt, 0);
            check("rst_vld", link.frame_vld, 0);
            check("rst_err", link.frame_err, 0);
        end
        link.ds = 1'b0; link.shcp = 1'b0; link.stcp = 1'b0; link.oe = 1'b1;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            check("post_rst_q", link.q, 0);
            check("post_rst_bit_cnt", link.bit_cnt, 0);
            check("post_rst_vld", link.frame_vld, 0);
        end

        // ---------------- table of whole frames
        foreach (vecs[v]) begin
            set_oe(vecs[v].oe);
            send_bits(vecs[v].data, vecs[v].nbits);
            check("tbl_cnt_before", link.bit_cnt, vecs[v].exp_cnt);
            pulse(1'b0, 1'b1, 1'b0, e, qv);
            $display("vector %0d: %0d bits data=%0h oe=%0d -> q=%0h err=%0d", v,
                     vecs[v].nbits, vecs[v].data, vecs[v].oe, qv, e);
            check("tbl_q", qv, vecs[v].exp_q);
            check("tbl_err", e, vecs[v].exp_err);
            check("tbl_cnt_after", link.bit_cnt, 0);
        end

        // ---------------- oe gating with 2-cycle latency (store holds 3A5C)
        @(negedge sys_clk);
        link.oe = 1'b1;
        @(negedge sys_clk);
        check("oe_hi_1_q", link.q, 14'h3A5C);
        check("oe_hi_1_q_en", link.q_en, 1);
        @(negedge sys_clk);
        check("oe_hi_2_q", link.q, 0);
        check("oe_hi_2_q_en", link.q_en, 0);
        link.oe = 1'b0;
        @(negedge sys_clk);
        check("oe_lo_1_q", link.q, 0);
        @(negedge sys_clk);
        check("oe_lo_2_q", link.q, 14'h3A5C);
        check("oe_lo_2_q_en", link.q_en, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            check("oe_no_vld", link.frame_vld, 0);
        end
        $display("oe gating: q=%0h q_en=%0d", link.q, link.q_en);

        // ---------------- simultaneous shift and latch
        send_bits(32'h1555, 14);
        pulse(1'b1, 1'b1, 1'b0, e, qv);
        $display("simultaneous: q=%0h err=%0d bit_cnt=%0d", qv, e, link.bit_cnt);
        check("sim_q", qv, 14'h1555);
        check("sim_err", e, 0);
        check("sim_cnt", link.bit_cnt, 1);

        // ---------------- randomized frames
        for (int f = 0; f < 20; f++) begin
            int nb = $urandom_range(10, 17);
            bit both = ($urandom % 4) == 0;
            set_oe(($urandom % 4) == 0);
            for (int b = 0; b < nb - 1; b++) pulse(1'b1, 1'b0, 1'($urandom), e, qv);
            if (both) pulse(1'b1, 1'b1, 1'($urandom), e, qv);
            else begin
                pulse(1'b1, 1'b0, 1'($urandom), e, qv);
                pulse(1'b0, 1'b1, 1'b0, e, qv);
            end
            $display("random frame %0d: bits=%0d both=%0d q=%0h err=%0d", f, nb, both, qv, e);
        end

        // ---------------- reset mid-frame
        set_oe(1'b0);
        send_bits(32'h7F, 7);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        check("mid_rst_cnt", link.bit_cnt, 0);
        check("mid_rst_q", link.q, 0);
        check("mid_rst_q_en", link.q_en, 0);
        model_reset();
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        pulse(1'b0, 1'b1, 1'b0, e, qv);
        check("mid_rst_empty_q", qv, 0);
        check("mid_rst_empty_err", e, 1);
        send_bits(32'h0001, 14);
        pulse(1'b0, 1'b1, 1'b0, e, qv);
        $display("after mid-frame reset: q=%0h err=%0d", qv, e);
        check("mid_rst_frame_q", qv, 14'h0001);
        check("mid_rst_frame_err", e, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
